// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock for the 5-stage core: load-use, multi-cycle MUL/DIV and memory-wait stalls.
// Optional perf counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 34,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic [4:0] id_rs_addr,
   input  logic [4:0] id_rt_addr,
   input  logic       id_rs_used,
   input  logic       id_rt_used,
   input  logic [4:0] ex_dest_addr,
   input  logic [1:0] ex_access_type,
   input  logic       ex_muldiv_start,
   input  logic       ex_is_div,
   input  logic       mm_mem_busy,
   output logic       stall_if,
   output logic       stall_id,
   output logic       stall_ex,
   output logic       stall_mm,
   output logic       bubble_ex,
   output logic       bubble_mm,
   output logic       bubble_wb,
   output logic       muldiv_busy,
   output logic       muldiv_done
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_loaduse_cnt,
   output logic [31:0] perf_muldiv_cnt,
   output logic [31:0] perf_memwait_cnt
`endif
);

   localparam logic [1:0] ACC_M2R = 2'b01;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, MULDIV, MEM_WAIT} state_t;

   state_t           state, state_nxt;
   state_t           saved, saved_nxt;
   state_t           base;
   logic [CNT_W-1:0] count, count_nxt;
   logic             md_start;
   logic             lu_hit;
   logic             lu_act, md_act, mw_act, done_act;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         saved <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         saved <= saved_nxt;
         count <= count_nxt;
      end
   end

   assign lu_hit = (ex_access_type == ACC_M2R) && (ex_dest_addr != 5'd0) &&
                   ((id_rs_used && (id_rs_addr == ex_dest_addr)) ||
                    (id_rt_used && (id_rt_addr == ex_dest_addr)));

   // During a memory wait the interrupted state lives in 'saved'; it resumes the cycle busy drops.
   always_comb begin
      state_nxt = state;
      saved_nxt = saved;
      count_nxt = count;
      lu_act    = 1'b0;
      md_act    = 1'b0;
      mw_act    = 1'b0;
      done_act  = 1'b0;
      base      = (state == MEM_WAIT) ? saved : state;
      md_start  = (base == IDLE) && ex_muldiv_start;
      if (!rst_n) begin
         state_nxt = IDLE;
      end else if (flush) begin
         state_nxt = IDLE;
         saved_nxt = IDLE;
         count_nxt = '0;
      end else if (mm_mem_busy) begin
         mw_act    = 1'b1;
         state_nxt = MEM_WAIT;
         if (md_start) begin
            saved_nxt = MULDIV;
            count_nxt = ex_is_div ? DIV_LOAD : MUL_LOAD;
         end else begin
            saved_nxt = base;
         end
      end else if (md_start || (base == MULDIV)) begin
         md_act = 1'b1;
         if (md_start) begin
            state_nxt = MULDIV;
            count_nxt = ex_is_div ? DIV_LOAD : MUL_LOAD;
         end else if (count == CNT_ONE) begin
            done_act  = 1'b1;
            state_nxt = IDLE;
            count_nxt = '0;
         end else begin
            state_nxt = MULDIV;
            count_nxt = count - CNT_ONE;
         end
      end else begin
         state_nxt = IDLE;
         lu_act    = lu_hit;
      end
   end

   assign stall_if    = lu_act | md_act | mw_act;
   assign stall_id    = lu_act | md_act | mw_act;
   assign stall_ex    = md_act | mw_act;
   assign stall_mm    = mw_act;
   assign bubble_ex   = lu_act;
   assign bubble_mm   = md_act;
   assign bubble_wb   = mw_act;
   assign muldiv_busy = md_act;
   assign muldiv_done = done_act;

`ifdef HAZARD_PERF_CNT_EN
   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_loaduse_cnt <= '0;
         perf_muldiv_cnt  <= '0;
         perf_memwait_cnt <= '0;
      end else begin
         if (lu_act) perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
         if (md_act) perf_muldiv_cnt  <= perf_muldiv_cnt + 32'd1;
         if (mw_act) perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, MUL/DIV, memory wait, flush and async reset.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [4:0] id_rs_addr, id_rt_addr, ex_dest_addr;
   logic       id_rs_used, id_rt_used;
   logic [1:0] ex_access_type;
   logic       ex_muldiv_start, ex_is_div, mm_mem_busy;
   logic       stall_if, stall_id, stall_ex, stall_mm;
   logic       bubble_ex, bubble_mm, bubble_wb, muldiv_busy, muldiv_done;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_loaduse_cnt, perf_muldiv_cnt, perf_memwait_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Output vector order: stall_if stall_id stall_ex stall_mm bubble_ex bubble_mm bubble_wb busy done
   localparam logic [8:0] O_ZERO = 9'b000000000;
   localparam logic [8:0] O_LU   = 9'b110010000;
   localparam logic [8:0] O_MD   = 9'b111001010;
   localparam logic [8:0] O_DONE = 9'b111001011;
   localparam logic [8:0] O_MW   = 9'b111100100;
   localparam logic [1:0] M2R    = 2'b01;
   localparam logic [1:0] R2R    = 2'b00;

   logic [8:0] outs;
   assign outs = {stall_if, stall_id, stall_ex, stall_mm, bubble_ex, bubble_mm,
                  bubble_wb, muldiv_busy, muldiv_done};

   hazard_stall_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .ex_dest_addr(ex_dest_addr), .ex_access_type(ex_access_type),
      .ex_muldiv_start(ex_muldiv_start), .ex_is_div(ex_is_div),
      .mm_mem_busy(mm_mem_busy),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mm(stall_mm),
      .bubble_ex(bubble_ex), .bubble_mm(bubble_mm), .bubble_wb(bubble_wb),
      .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_loaduse_cnt(perf_loaduse_cnt), .perf_muldiv_cnt(perf_muldiv_cnt),
      .perf_memwait_cnt(perf_memwait_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; inputs are applied here.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_outs(input string tag, input logic [8:0] exp);
      #3;
      check(tag, {23'd0, outs}, {23'd0, exp});
   endtask

   task automatic clear_id();
      id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
      ex_dest_addr = 5'd0; ex_access_type = R2R;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; ex_muldiv_start = 1'b0; ex_is_div = 1'b0; mm_mem_busy = 1'b0;
      // A live load-use pattern during reset must still give all-zero outputs.
      id_rs_addr = 5'd5; id_rs_used = 1'b1; id_rt_addr = 5'd0; id_rt_used = 1'b0;
      ex_dest_addr = 5'd5; ex_access_type = M2R;
      #12;
      check("reset_outs", {23'd0, outs}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("reset_perf_lu", perf_loaduse_cnt, 32'd0);
`endif
      clear_id();
      next_cycle();
      rst_n = 1'b1;
      expect_outs("idle_after_reset", O_ZERO);

      // Load-use on rs, then the load moves on
      next_cycle();
      ex_access_type = M2R; ex_dest_addr = 5'd5; id_rs_addr = 5'd5; id_rs_used = 1'b1;
      expect_outs("lu_rs", O_LU);
      next_cycle();
      clear_id();
      expect_outs("lu_cleared", O_ZERO);

      // Load-use on rt
      next_cycle();
      ex_access_type = M2R; ex_dest_addr = 5'd9; id_rt_addr = 5'd9; id_rt_used = 1'b1;
      id_rs_addr = 5'd3; id_rs_used = 1'b1;
      expect_outs("lu_rt", O_LU);

      // No-hazard variants
      next_cycle();
      clear_id();
      ex_access_type = M2R; ex_dest_addr = 5'd0; id_rs_addr = 5'd0; id_rs_used = 1'b1;
      expect_outs("nohaz_dest0", O_ZERO);
      next_cycle();
      ex_dest_addr = 5'd5; id_rs_addr = 5'd5; id_rs_used = 1'b0;
      expect_outs("nohaz_unused", O_ZERO);
      next_cycle();
      ex_access_type = R2R; id_rs_used = 1'b1;
      expect_outs("nohaz_r2r", O_ZERO);

      // MUL: three busy cycles, done on the third; load-use masked meanwhile
      next_cycle();
      clear_id();
      ex_muldiv_start = 1'b1; ex_is_div = 1'b0;
      expect_outs("mul_c1", O_MD);
      next_cycle();
      ex_muldiv_start = 1'b0;
      ex_access_type = M2R; ex_dest_addr = 5'd7; id_rs_addr = 5'd7; id_rs_used = 1'b1;
      expect_outs("mul_c2_lu_masked", O_MD);
      next_cycle();
      clear_id();
      expect_outs("mul_c3_done", O_DONE);
      next_cycle();
      expect_outs("mul_idle", O_ZERO);
`ifdef HAZARD_PERF_CNT_EN
      check("perf_lu_count", perf_loaduse_cnt, 32'd2);
`endif

      // DIV with memory wait in cycles 5-8; done lands on cycle 38
      for (int c = 1; c <= 39; c++) begin
         next_cycle();
         ex_muldiv_start = (c == 1);
         ex_is_div = 1'b1;
         mm_mem_busy = (c >= 5) && (c <= 8);
         if (c < 5)       expect_outs("div_busy", O_MD);
         else if (c <= 8) expect_outs("div_memwait", O_MW);
         else if (c < 38) expect_outs("div_resume", O_MD);
         else if (c == 38) expect_outs("div_done", O_DONE);
         else             expect_outs("div_idle", O_ZERO);
      end

      // Flush in cycle 10 of a DIV: nothing afterwards, no done pulse
      for (int c = 1; c <= 40; c++) begin
         next_cycle();
         ex_muldiv_start = (c == 1);
         ex_is_div = 1'b1;
         flush = (c == 10);
         if (c < 10) expect_outs("flush_pre", O_MD);
         else        expect_outs("flush_post", O_ZERO);
      end

      // New MUL after flush works normally
      next_cycle();
      ex_muldiv_start = 1'b1; ex_is_div = 1'b0;
      expect_outs("mul2_c1", O_MD);
      next_cycle();
      ex_muldiv_start = 1'b0;
      expect_outs("mul2_c2", O_MD);
      next_cycle();
      expect_outs("mul2_c3_done", O_DONE);

      // Start coincident with memory wait: start is kept and MUL resumes after the wait
      next_cycle();
      ex_muldiv_start = 1'b1; mm_mem_busy = 1'b1;
      expect_outs("sim_c1_wait", O_MW);
      next_cycle();
      ex_muldiv_start = 1'b0;
      expect_outs("sim_c2_wait", O_MW);
      next_cycle();
      mm_mem_busy = 1'b0;
      expect_outs("sim_c3_busy", O_MD);
      next_cycle();
      expect_outs("sim_c4_done", O_DONE);
      next_cycle();
      expect_outs("sim_idle", O_ZERO);

      // Asynchronous reset in the middle of a MUL
      next_cycle();
      ex_muldiv_start = 1'b1;
      expect_outs("ar_start", O_MD);
      next_cycle();
      ex_muldiv_start = 1'b0;
      expect_outs("ar_busy", O_MD);
      rst_n = 1'b0;
      #1;
      check("ar_outs_async", {23'd0, outs}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      check("ar_perf_lu", perf_loaduse_cnt, 32'd0);
      check("ar_perf_md", perf_muldiv_cnt, 32'd0);
      check("ar_perf_mw", perf_memwait_cnt, 32'd0);
`endif
      next_cycle();
      rst_n = 1'b1;
      expect_outs("ar_idle", O_ZERO);
      next_cycle();
      expect_outs("ar_idle2", O_ZERO);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
